// File: rtl/imul_seq_if.sv
// -----------------------------------------------------------------------------
// imul_seq_if
//
// Purpose:
//   Handshake bundle between the mantissa multiplier and its neighbours.
//   It carries the operand channel from upstream and the product channel
//   to the normalise/exponent-adjust stage.
//
// Parameters:
//   WIDTH      operand width in bits (hidden bit included)
//
// Signals:
//   in_valid   upstream -> mul   operands a/b valid
//   in_ready   mul -> upstream   multiplier can accept operands
//   a          upstream -> mul   multiplicand, unsigned, WIDTH bits
//   b          upstream -> mul   multiplier, unsigned, WIDTH bits
//   out_valid  mul -> consumer   product valid
//   out_ready  consumer -> mul   consumer accepts product
//   out        mul -> consumer   unsigned product a*b, 2*WIDTH bits
//
// Modports:
//   master     operand producer / product consumer (e.g. the testbench)
//   slave      the multiplier itself
// -----------------------------------------------------------------------------
interface imul_seq_if #(
    parameter int WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out
    );
endinterface

// File: rtl/imul_seq.sv
// -----------------------------------------------------------------------------
// imul_seq
//
// Purpose:
//   Iterative, handshaked unsigned mantissa multiplier for the FPU datapath.
//   Two WIDTH-bit mantissas produce the full, unrounded 2*WIDTH-bit product,
//   used as mant_mul by the single-precision normalise/exponent-adjust logic.
//   A shift-and-add loop retires multiplier bits one (radix-2) or two
//   (radix-4) per cycle. Latency is data-independent.
//
// Build option:
//   IMUL_SEQ_RADIX4_EN   when defined, two multiplier bits are retired per
//                        cycle (N = WIDTH/2). Otherwise radix-2 (N = WIDTH).
//
// Parameters:
//   WIDTH      operand width in bits, must be >= 2 and even (default 24)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mul_if     imul_seq_if.slave bundle:
//                in_valid/in_ready/a/b        operand handshake
//                out_valid/out_ready/out      product handshake
//
// Timing:
//   Operands are accepted on edge 0. The iterations run on edges 1..N, and
//   out_valid is high from cycle N+1 until out_ready is seen. in_ready is
//   low outside IDLE, so the minimum issue interval is N+2 cycles.
// -----------------------------------------------------------------------------
module imul_seq #(
    parameter int WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst,
    imul_seq_if.slave   mul_if
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
`ifdef IMUL_SEQ_RADIX4_EN
    localparam int N = WIDTH / 2;
`else
    localparam int N = WIDTH;
`endif
    localparam int CNT_W = $clog2(N + 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("imul_seq: WIDTH must be >= 2 and even");
    end

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]     out_q, out_d;
`ifdef IMUL_SEQ_RADIX4_EN
    // 3*mcand needs two extra bits; it is built once per job so the
    // per-iteration path is a single W+2 bit adder behind a 4:1 mux.
    logic [WIDTH+1:0]       mcand3_q, mcand3_d;
`endif

    logic                   in_ready;
    logic                   out_valid;

    // -------------------------------------------------------------------------
    // One iteration of the shift-and-add loop
    // -------------------------------------------------------------------------
`ifdef IMUL_SEQ_RADIX4_EN
    // Add 0/1/2/3 * mcand into the upper half, then shift right by two.
    // The upper half stays below 2^W, so the W+2 bit sum cannot overflow.
    function automatic logic [2*WIDTH-1:0] radix4_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   mcand,
        input logic [WIDTH+1:0]   mcand3,
        input logic [1:0]         sel
    );
        logic [WIDTH+1:0] addend;
        logic [WIDTH+1:0] sum;
        case (sel)
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, mcand};
            2'd2:    addend = {1'b0, mcand, 1'b0};
            default: addend = mcand3;
        endcase
        sum = {2'b00, acc[2*WIDTH-1:WIDTH]} + addend;
        return (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 2);
    endfunction
`else
    // Add mcand into the upper half when the current multiplier bit is set,
    // then shift {carry, sum, lower half} right by one.
    function automatic logic [2*WIDTH-1:0] radix2_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   mcand,
        input logic               sel
    );
        logic [WIDTH:0] addend;
        logic [WIDTH:0] sum;
        addend = sel ? {1'b0, mcand} : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        return (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
`ifdef IMUL_SEQ_RADIX4_EN
            mcand3_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            out_q    <= out_d;
`ifdef IMUL_SEQ_RADIX4_EN
            mcand3_q <= mcand3_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, datapath and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        out_d     = out_q;
`ifdef IMUL_SEQ_RADIX4_EN
        mcand3_d  = mcand3_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is masked by rst so nothing upstream can see a
                // handshake that the asynchronous reset will swallow.
                in_ready = !rst;
                if (mul_if.in_valid) begin
                    mcand_d  = mul_if.a;
                    mplier_d = mul_if.b;
                    acc_d    = '0;
                    count_d  = CNT_W'(N);
`ifdef IMUL_SEQ_RADIX4_EN
                    mcand3_d = {2'b00, mul_if.a} + {1'b0, mul_if.a, 1'b0};
`endif
                    state_d  = RUN;
                end
            end

            RUN: begin
`ifdef IMUL_SEQ_RADIX4_EN
                acc_d    = radix4_step(acc_q, mcand_q, mcand3_q, mplier_q[1:0]);
                mplier_d = mplier_q >> 2;
`else
                acc_d    = radix2_step(acc_q, mcand_q, mplier_q[0]);
                mplier_d = mplier_q >> 1;
`endif
                count_d  = count_q - 1'b1;
                // The last iteration writes its own result straight into the
                // output register so DONE presents the finished product.
                if (count_q == CNT_W'(1)) begin
                    out_d   = acc_d;
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (mul_if.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mul_if.in_ready  = in_ready;
    assign mul_if.out_valid = out_valid;
    assign mul_if.out       = out_q;

endmodule
